// File: rtl/act_window_scheduler.sv
// Activation-memory controller: streams a feature map into the memory (LOAD), then walks the
// window origin over every output position (SWEEP). Optional macro ACT_SCHED_PERF_EN adds stall counters.
module act_window_scheduler #(
  parameter int ENTRY_NUM  = 16,
  parameter int DIM        = 8,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 1,
  parameter int DATA_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 mem_write,
  output logic [15:0]          mem_index_entry,
  output logic [15:0]          mem_index_y,
  output logic [15:0]          mem_index_x,
  output logic [DATA_SIZE-1:0] mem_in_data,
  output logic [15:0]          mem_read_y,
  output logic [15:0]          mem_read_x,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [15:0]          win_oy,
  output logic [15:0]          win_ox,
  output logic                 win_last
`ifdef ACT_SCHED_PERF_EN
  ,
  output logic [31:0]          load_stall_cnt,
  output logic [31:0]          sweep_stall_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | accepting load stream, write counters advance per word
  // SWEEP | presenting windows, origin advances per handshake
  // DONE  | single-cycle completion pulse

  localparam int OUT_DIM = (DIM - KERNEL_DIM) / STRIDE + 1;
  localparam logic [15:0] ENTRY_LAST = 16'(ENTRY_NUM - 1);
  localparam logic [15:0] DIM_LAST   = 16'(DIM - 1);
  localparam logic [15:0] OUT_LAST   = 16'(OUT_DIM - 1);
  localparam logic [15:0] STRIDE_W   = 16'(STRIDE);

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0] cnt_entry, cnt_y, cnt_x;
  logic [15:0] cnt_oy, cnt_ox;

  logic load_fire, load_x_wrap, load_y_wrap, load_last;
  logic win_fire, sweep_last;

  assign load_fire   = (state == LOAD) && in_valid;
  assign load_x_wrap = (cnt_x == DIM_LAST);
  assign load_y_wrap = (cnt_y == DIM_LAST);
  assign load_last   = load_fire && load_x_wrap && load_y_wrap && (cnt_entry == ENTRY_LAST);

  assign sweep_last  = (cnt_oy == OUT_LAST) && (cnt_ox == OUT_LAST);
  assign win_fire    = (state == SWEEP) && win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    in_ready  = 1'b0;
    win_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (load_last) state_nxt = SWEEP;
      end
      SWEEP: begin
        win_valid = 1'b1;
        if (win_fire && sweep_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write address is the counter value before the increment; all counters return to 0 on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_entry <= '0;
      cnt_y     <= '0;
      cnt_x     <= '0;
    end else if ((state == IDLE) && start) begin
      cnt_entry <= '0;
      cnt_y     <= '0;
      cnt_x     <= '0;
    end else if (load_fire) begin
      if (load_last) begin
        cnt_entry <= '0;
        cnt_y     <= '0;
        cnt_x     <= '0;
      end else if (load_x_wrap) begin
        cnt_x <= '0;
        if (load_y_wrap) begin
          cnt_y     <= '0;
          cnt_entry <= cnt_entry + 16'd1;
        end else begin
          cnt_y <= cnt_y + 16'd1;
        end
      end else begin
        cnt_x <= cnt_x + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_oy <= '0;
      cnt_ox <= '0;
    end else if ((state == IDLE) && start) begin
      cnt_oy <= '0;
      cnt_ox <= '0;
    end else if (win_fire) begin
      if (sweep_last) begin
        cnt_oy <= '0;
        cnt_ox <= '0;
      end else if (cnt_ox == OUT_LAST) begin
        cnt_ox <= '0;
        cnt_oy <= cnt_oy + 16'd1;
      end else begin
        cnt_ox <= cnt_ox + 16'd1;
      end
    end
  end

  assign mem_write       = in_valid && in_ready;
  assign mem_index_entry = cnt_entry;
  assign mem_index_y     = cnt_y;
  assign mem_index_x     = cnt_x;
  assign mem_in_data     = in_data;

  // Origins are only driven while a window is presented so idle reads sit at 0.
  assign mem_read_y = (state == SWEEP) ? cnt_oy * STRIDE_W : 16'd0;
  assign mem_read_x = (state == SWEEP) ? cnt_ox * STRIDE_W : 16'd0;
  assign win_oy     = (state == SWEEP) ? cnt_oy : 16'd0;
  assign win_ox     = (state == SWEEP) ? cnt_ox : 16'd0;
  assign win_last   = win_valid && sweep_last;

`ifdef ACT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt  <= '0;
      sweep_stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      load_stall_cnt  <= '0;
      sweep_stall_cnt <= '0;
    end else begin
      if ((state == LOAD) && !in_valid && (load_stall_cnt != 32'hFFFF_FFFF))
        load_stall_cnt <= load_stall_cnt + 32'd1;
      if ((state == SWEEP) && !win_ready && (sweep_stall_cnt != 32'hFFFF_FFFF))
        sweep_stall_cnt <= sweep_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_window_scheduler.sv
// Scoreboard bench for act_window_scheduler: dut_a (2 entries, DIM 4, K3 S1), dut_b (1 entry, DIM 7, K3 S2).
module tb_act_window_scheduler;

  typedef struct {
    logic [15:0] e, y, x;
    logic [63:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] oy, ox, ry, rx;
    logic        last;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_start, a_busy, a_done, a_in_valid, a_in_ready, a_mem_write;
  logic [63:0] a_in_data, a_mem_in_data;
  logic [15:0] a_idx_e, a_idx_y, a_idx_x, a_rd_y, a_rd_x, a_oy, a_ox;
  logic        a_win_valid, a_win_ready, a_win_last;
  logic        b_start, b_busy, b_done, b_in_valid, b_in_ready, b_mem_write;
  logic [63:0] b_in_data, b_mem_in_data;
  logic [15:0] b_idx_e, b_idx_y, b_idx_x, b_rd_y, b_rd_x, b_oy, b_ox;
  logic        b_win_valid, b_win_ready, b_win_last;
`ifdef ACT_SCHED_PERF_EN
  logic [31:0] a_lsc, a_ssc, b_lsc, b_ssc;
`endif

  act_window_scheduler #(.ENTRY_NUM(2), .DIM(4), .KERNEL_DIM(3), .STRIDE(1), .DATA_SIZE(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .mem_write(a_mem_write),
    .mem_index_entry(a_idx_e), .mem_index_y(a_idx_y), .mem_index_x(a_idx_x),
    .mem_in_data(a_mem_in_data), .mem_read_y(a_rd_y), .mem_read_x(a_rd_x),
    .win_valid(a_win_valid), .win_ready(a_win_ready), .win_oy(a_oy), .win_ox(a_ox),
    .win_last(a_win_last)
`ifdef ACT_SCHED_PERF_EN
    , .load_stall_cnt(a_lsc), .sweep_stall_cnt(a_ssc)
`endif
  );

  act_window_scheduler #(.ENTRY_NUM(1), .DIM(7), .KERNEL_DIM(3), .STRIDE(2), .DATA_SIZE(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .mem_write(b_mem_write),
    .mem_index_entry(b_idx_e), .mem_index_y(b_idx_y), .mem_index_x(b_idx_x),
    .mem_in_data(b_mem_in_data), .mem_read_y(b_rd_y), .mem_read_x(b_rd_x),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .win_oy(b_oy), .win_ox(b_ox),
    .win_last(b_win_last)
`ifdef ACT_SCHED_PERF_EN
    , .load_stall_cnt(b_lsc), .sweep_stall_cnt(b_ssc)
`endif
  );

  int checks = 0;
  int errors = 0;
  wr_t  qa_w[$];
  win_t qa_win[$];
  win_t qb_win[$];
  wr_t  mw;
  win_t mwa, mwb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: compare whatever the DUT presents against the front of the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_mem_write) begin
        if (qa_w.size() == 0) chk("a_wr_unexpected", 64'd1, 64'd0);
        else begin
          mw = qa_w.pop_front();
          chk("a_wr_entry", 64'(a_idx_e), 64'(mw.e));
          chk("a_wr_y", 64'(a_idx_y), 64'(mw.y));
          chk("a_wr_x", 64'(a_idx_x), 64'(mw.x));
          chk("a_wr_data", a_mem_in_data, mw.d);
        end
      end
      if (a_win_valid) begin
        if (qa_win.size() == 0) chk("a_win_unexpected", 64'd1, 64'd0);
        else begin
          mwa = qa_win[0];
          chk("a_win_oy", 64'(a_oy), 64'(mwa.oy));
          chk("a_win_ox", 64'(a_ox), 64'(mwa.ox));
          chk("a_rd_y", 64'(a_rd_y), 64'(mwa.ry));
          chk("a_rd_x", 64'(a_rd_x), 64'(mwa.rx));
          chk("a_win_last", 64'(a_win_last), 64'(mwa.last));
          if (a_win_ready) void'(qa_win.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_win_valid) begin
      if (qb_win.size() == 0) chk("b_win_unexpected", 64'd1, 64'd0);
      else begin
        mwb = qb_win[0];
        chk("b_win_oy", 64'(b_oy), 64'(mwb.oy));
        chk("b_win_ox", 64'(b_ox), 64'(mwb.ox));
        chk("b_rd_y", 64'(b_rd_y), 64'(mwb.ry));
        chk("b_rd_x", 64'(b_rd_x), 64'(mwb.rx));
        chk("b_win_last", 64'(b_win_last), 64'(mwb.last));
        if (b_win_ready) void'(qb_win.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic load_a(input int gap_at, input int gaps);
    for (int e = 0; e < 2; e++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          if (e * 16 + y * 4 + x == gap_at) begin
            a_in_valid = 1'b0;
            repeat (gaps) tick();
          end
          qa_w.push_back(wr_t'{16'(e), 16'(y), 16'(x), {16'hA5A5, 16'(e), 16'(y), 16'(x)}});
          a_in_valid = 1'b1;
          a_in_data  = {16'hA5A5, 16'(e), 16'(y), 16'(x)};
          tick();
        end
    a_in_valid = 1'b0;
  endtask

  task automatic sweep_a(input int stall_at, input int stalls, input int n_hs);
    for (int k = 0; k < 4; k++)
      qa_win.push_back(win_t'{16'(k / 2), 16'(k % 2), 16'(k / 2), 16'(k % 2), (k == 3)});
    for (int k = 0; k < n_hs; k++) begin
      if (k == stall_at) begin
        a_win_ready = 1'b0;
        repeat (stalls) tick();
      end
      a_win_ready = 1'b1;
      tick();
    end
    a_win_ready = 1'b0;
  endtask

  task automatic done_a();
    #1;
    chk("a_done_pulse", 64'(a_done), 64'd1);
    chk("a_done_busy", 64'(a_busy), 64'd1);
    chk("a_done_win_valid", 64'(a_win_valid), 64'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    #1;
    chk("a_idle_busy", 64'(a_busy), 64'd0);
    chk("a_idle_done", 64'(a_done), 64'd0);
    tick();
    chk("a_start_in_done_ignored", 64'(a_in_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int hs, cyc;
    rst_n = 1'b0;
    a_start = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_win_ready = 1'b0;
    b_start = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_win_ready = 1'b0;
    #12;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_win_valid", 64'(a_win_valid), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_rd_y", 64'(a_rd_y), 64'd0);
    a_start = 1'b0; b_start = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_release_busy", 64'(a_busy), 64'd0);
    chk("rst_release_in_ready", 64'(a_in_ready), 64'd0);

    // Load 32 words continuously, then sweep 2x2 windows
    start_a();
    #1;
    chk("a_first_in_ready", 64'(a_in_ready), 64'd1);
    load_a(-1, 0);
    #1;
    chk("a_sweep_after_32", 64'(a_win_valid), 64'd1);
    chk("a_in_ready_off", 64'(a_in_ready), 64'd0);
    chk("a_wr_queue_drained", 64'(qa_w.size()), 64'd0);
    sweep_a(1, 2, 4);
    done_a();
    chk("a_win_queue_drained", 64'(qa_win.size()), 64'd0);

    // Stride 2 on DIM 7: random ready gaps
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_in_valid = 1'b1;
    for (int i = 0; i < 49; i++) begin
      b_in_data = 64'(i);
      tick();
    end
    b_in_valid = 1'b0;
    #1;
    chk("b_sweep_entered", 64'(b_win_valid), 64'd1);
    for (int k = 0; k < 9; k++)
      qb_win.push_back(win_t'{16'(k / 3), 16'(k % 3), 16'(2 * (k / 3)), 16'(2 * (k % 3)), (k == 8)});
    hs = 0;
    cyc = 0;
    while (hs < 9 && cyc < 300) begin
      b_win_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (b_win_valid && b_win_ready) hs++;
      tick();
      cyc++;
    end
    b_win_ready = 1'b0;
    chk("b_handshakes", 64'(hs), 64'd9);
    chk("b_done_pulse", 64'(b_done), 64'd1);
    chk("b_win_queue_drained", 64'(qb_win.size()), 64'd0);
    tick();

    // Reset mid-sweep at window (1,0), then a full clean pass
    start_a();
    load_a(-1, 0);
    sweep_a(-1, 0, 2);
    #1;
    chk("a_mid_oy", 64'(a_oy), 64'd1);
    chk("a_mid_ox", 64'(a_ox), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("a_rst_mid_busy", 64'(a_busy), 64'd0);
    chk("a_rst_mid_win_valid", 64'(a_win_valid), 64'd0);
    chk("a_rst_mid_rd_y", 64'(a_rd_y), 64'd0);
    qa_win.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_a();
    load_a(-1, 0);
    sweep_a(-1, 0, 4);
    done_a();
    chk("a_rerun_win_drained", 64'(qa_win.size()), 64'd0);

`ifdef ACT_SCHED_PERF_EN
    start_a();
    load_a(10, 5);
    sweep_a(2, 3, 4);
    #1;
    chk("perf_load_stall", 64'(a_lsc), 64'd5);
    chk("perf_sweep_stall", 64'(a_ssc), 64'd3);
    done_a();
    chk("perf_load_hold", 64'(a_lsc), 64'd5);
    chk("perf_sweep_hold", 64'(a_ssc), 64'd3);
`endif

    chk("a_wr_queue_final", 64'(qa_w.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
